// File: rtl/c3lib_sync_meta_model_mc.sv
// c3lib_sync_meta_model_mc: multi-channel bit synchronizer with a runtime-enabled,
// LFSR-driven metastability model that delays selected channels by one cycle.
module c3lib_sync_meta_model_mc #(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
   parameter int               META_COUNT  = 256,
   parameter logic [31:0]      LFSR_SEED   = 32'h0000_0001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             meta_en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] data_rise,
   output logic [WIDTH-1:0] data_fall,
   output logic             meta_event,
   output logic [15:0]      meta_event_cnt
);

   localparam int               CNT_W     = (META_COUNT < 32'sd1) ? 1 : $clog2(META_COUNT + 32'sd1);
   localparam logic [CNT_W-1:0] META_LAST = CNT_W'(META_COUNT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
   localparam logic [31:0]      SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h0000_0001 : LFSR_SEED;

   if (WIDTH < 32'sd1 || WIDTH > 32'sd32 || SYNC_STAGES < 32'sd2 || SYNC_STAGES > 32'sd8 ||
       META_COUNT < 32'sd1) begin : g_param_check
      $error("c3lib_sync_meta_model_mc: parameter out of range");
   end

   // Galois LFSR step, taps x^32+x^22+x^2+x+1, shifting right.
   function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
      logic [31:0] shifted;
      shifted = {1'b0, cur[31:1]};
      return cur[0] ? (shifted ^ 32'h8020_0003) : shifted;
   endfunction

   logic [CNT_W-1:0] interval_r;
   logic [31:0]      lfsr_r;
   logic [31:0]      lfsr_nxt_s;
   logic             period_end_s;
   logic [WIDTH-1:0] meta_mask_r;
   logic [WIDTH-1:0] meta_mask_nxt_s;
   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] stage0_s;
   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] hist_r;
   logic [WIDTH-1:0] rise_r;
   logic [WIDTH-1:0] fall_r;
   logic             meta_event_r;
   logic [15:0]      meta_event_cnt_r;

   // Next mask is only nonzero on the last cycle of an injection period.
   always_comb begin
      lfsr_nxt_s      = lfsr_next(lfsr_r);
      period_end_s    = (interval_r == META_LAST);
      meta_mask_nxt_s = {WIDTH{1'b0}};
      if (period_end_s) begin
         meta_mask_nxt_s = lfsr_nxt_s[WIDTH-1:0] & {WIDTH{meta_en}};
      end else begin
         meta_mask_nxt_s = {WIDTH{1'b0}};
      end
      stage0_s = (meta_mask_r & meta_r) | (~meta_mask_r & data_in);
   end

   // Interval counter, LFSR and one-cycle injection mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         interval_r  <= {CNT_W{1'b0}};
         lfsr_r      <= SEED_EFF;
         meta_mask_r <= {WIDTH{1'b0}};
      end else begin
         interval_r  <= period_end_s ? {CNT_W{1'b0}} : (interval_r + CNT_ONE);
         lfsr_r      <= period_end_s ? lfsr_nxt_s : lfsr_r;
         meta_mask_r <= meta_mask_nxt_s;
      end
   end

   // Synchronizer chain; masked channels load last cycle's sample into stage 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= RESET_VAL;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= RESET_VAL;
         end
      end else begin
         meta_r    <= data_in;
         sync_r[0] <= stage0_s;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // Edge pulses against the delayed output, plus injection event statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_r           <= RESET_VAL;
         rise_r           <= {WIDTH{1'b0}};
         fall_r           <= {WIDTH{1'b0}};
         meta_event_r     <= 1'b0;
         meta_event_cnt_r <= 16'h0000;
      end else begin
         hist_r       <= sync_r[SYNC_STAGES-1];
         rise_r       <= sync_r[SYNC_STAGES-1] & ~hist_r;
         fall_r       <= ~sync_r[SYNC_STAGES-1] & hist_r;
         meta_event_r <= |meta_mask_r;
         if (meta_event_r && (meta_event_cnt_r != 16'hFFFF)) begin
            meta_event_cnt_r <= meta_event_cnt_r + 16'h0001;
         end
      end
   end

   assign data_out       = sync_r[SYNC_STAGES-1];
   assign data_rise      = rise_r;
   assign data_fall      = fall_r;
   assign meta_event     = meta_event_r;
   assign meta_event_cnt = meta_event_cnt_r;

endmodule

// File: tb/tb_c3lib_sync_meta_model_mc.sv
// Bench for c3lib_sync_meta_model_mc: three configurations checked every cycle
// against an edge-indexed behavioural model, plus hand-computed literal checks.
module tb_c3lib_sync_meta_model_mc;

   localparam int          NI = 3;
   localparam int          HD = 4096;
   localparam int          PW   [NI] = '{8, 32, 1};
   localparam int          PS   [NI] = '{2, 5, 2};
   localparam int          PMC  [NI] = '{4, 1, 3};
   localparam logic [31:0] PRV  [NI] = '{32'h0000_00A5, 32'h0, 32'h1};
   localparam logic [31:0] PSD  [NI] = '{32'h1, 32'h1, 32'h1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        meta_en;
   logic [31:0] din;

   logic [7:0]  a_out, a_rise, a_fall;
   logic [31:0] b_out, b_rise, b_fall;
   logic [0:0]  c_out, c_rise, c_fall;
   logic        a_ev, b_ev, c_ev;
   logic [15:0] a_cnt, b_cnt, c_cnt;

   c3lib_sync_meta_model_mc #(.WIDTH(8), .SYNC_STAGES(2), .RESET_VAL(8'hA5),
      .META_COUNT(4), .LFSR_SEED(32'h1)) u_a (
      .clk(clk), .rst(rst), .meta_en(meta_en), .data_in(din[7:0]),
      .data_out(a_out), .data_rise(a_rise), .data_fall(a_fall),
      .meta_event(a_ev), .meta_event_cnt(a_cnt));

   c3lib_sync_meta_model_mc #(.WIDTH(32), .SYNC_STAGES(5), .RESET_VAL(32'h0),
      .META_COUNT(1), .LFSR_SEED(32'h0)) u_b (
      .clk(clk), .rst(rst), .meta_en(meta_en), .data_in(din),
      .data_out(b_out), .data_rise(b_rise), .data_fall(b_fall),
      .meta_event(b_ev), .meta_event_cnt(b_cnt));

   c3lib_sync_meta_model_mc #(.WIDTH(1), .SYNC_STAGES(2), .RESET_VAL(1'b1),
      .META_COUNT(3), .LFSR_SEED(32'h0)) u_c (
      .clk(clk), .rst(rst), .meta_en(meta_en), .data_in(din[0:0]),
      .data_out(c_out), .data_rise(c_rise), .data_fall(c_fall),
      .meta_event(c_ev), .meta_event_cnt(c_cnt));

   logic [31:0] d_out [NI], d_rise [NI], d_fall [NI];
   logic        d_ev  [NI];
   logic [15:0] d_cnt [NI];
   assign d_out[0] = {24'h0, a_out};  assign d_rise[0] = {24'h0, a_rise};  assign d_fall[0] = {24'h0, a_fall};
   assign d_out[1] = b_out;           assign d_rise[1] = b_rise;           assign d_fall[1] = b_fall;
   assign d_out[2] = {31'h0, c_out};  assign d_rise[2] = {31'h0, c_rise};  assign d_fall[2] = {31'h0, c_fall};
   assign d_ev[0] = a_ev;   assign d_ev[1] = b_ev;   assign d_ev[2] = c_ev;
   assign d_cnt[0] = a_cnt; assign d_cnt[1] = b_cnt; assign d_cnt[2] = c_cnt;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model, indexed by edge number since reset ----------
   // in[n]   : input sampled at edge n (in[0] = reset value held in the meta flop)
   // mask(n) : nonzero only at n = m*(MC+1)+1, m>=1, = m-th LFSR state & meta_en(n-1)
   // st0[n]  : mask ? in[n-1] : in[n];  out[n] = st0[n-S+1] or reset value
   bit          m_valid [NI];
   int          m_n     [NI];
   logic [31:0] m_lfsr  [NI];
   logic [31:0] m_in    [NI][HD];
   logic [31:0] m_st0   [NI][HD];
   logic [31:0] m_out   [NI][HD];
   logic        m_en    [NI][HD];
   logic        m_ev    [NI][HD];
   logic [15:0] m_cnt   [NI][HD];
   logic [31:0] e_rise  [NI], e_fall [NI];
   bit          force_b = 1'b0;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      logic [31:0] r;
      r = v / 32'd2;
      if (v[0]) r = r ^ 32'h8020_0003;
      return r;
   endfunction

   function automatic logic [31:0] wmask(input int w);
      logic [63:0] one;
      one = 64'd1;
      return 32'((one << w) - 64'd1);
   endfunction

   task automatic model_edge(input int p);
      int          n, i, ip;
      logic [31:0] msk, o1, o2, wm;
      wm = wmask(PW[p]);
      if (rst) begin
         m_valid[p]  = 1'b1;
         m_n[p]      = 0;
         m_lfsr[p]   = PSD[p];
         m_in[p][0]  = PRV[p];
         m_out[p][0] = PRV[p];
         m_en[p][0]  = meta_en;
         m_ev[p][0]  = 1'b0;
         m_cnt[p][0] = 16'h0;
         e_rise[p]   = 32'h0;
         e_fall[p]   = 32'h0;
      end else if (m_valid[p]) begin
         n  = m_n[p] + 1;
         m_n[p] = n;
         i  = n % HD;
         ip = (n - 1) % HD;
         m_in[p][i] = din & wm;
         m_en[p][i] = meta_en;
         msk = 32'h0;
         if (n > 1 && ((n - 1) % (PMC[p] + 1)) == 0) begin
            m_lfsr[p] = lfsr_step(m_lfsr[p]);
            if (m_en[p][ip]) msk = m_lfsr[p] & wm;
         end
         m_st0[p][i] = (msk & m_in[p][ip]) | (~msk & m_in[p][i]);
         m_out[p][i] = (n - PS[p] + 1 >= 1) ? m_st0[p][(n - PS[p] + 1) % HD] : PRV[p];
         o1 = m_out[p][ip];
         o2 = (n >= 2) ? m_out[p][(n - 2) % HD] : PRV[p];
         e_rise[p]  = o1 & ~o2;
         e_fall[p]  = ~o1 & o2;
         m_ev[p][i] = |msk;
         if (p == 1 && force_b)
            m_cnt[p][i] = 16'hFFFC;
         else if (m_cnt[p][ip] == 16'hFFFF)
            m_cnt[p][i] = 16'hFFFF;
         else
            m_cnt[p][i] = m_cnt[p][ip] + {15'h0, m_ev[p][ip]};
      end
   endtask

   // Model advances on every active edge, sampling the same inputs as the DUTs.
   always @(posedge clk) begin
      for (int p = 0; p < NI; p++) model_edge(p);
   end

   // Every cycle after the first reset, every output of every instance is compared.
   always @(negedge clk) begin
      for (int p = 0; p < NI; p++) begin
         if (m_valid[p]) begin
            chk($sformatf("i%0d_out", p),  d_out[p],  m_out[p][m_n[p] % HD]);
            chk($sformatf("i%0d_rise", p), d_rise[p], e_rise[p]);
            chk($sformatf("i%0d_fall", p), d_fall[p], e_fall[p]);
            chk($sformatf("i%0d_ev", p),   {31'h0, d_ev[p]}, {31'h0, m_ev[p][m_n[p] % HD]});
            chk($sformatf("i%0d_cnt", p),  {16'h0, d_cnt[p]}, {16'h0, m_cnt[p][m_n[p] % HD]});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; meta_en = 1'b0; din = 32'h0000_00A5;
      repeat (3) @(negedge clk);
      chk("rst_out",  {24'h0, a_out},  32'h0000_00A5);
      chk("rst_rise", {24'h0, a_rise}, 32'h0);
      chk("rst_fall", {24'h0, a_fall}, 32'h0);
      chk("rst_cnt",  {16'h0, a_cnt},  32'h0);
      chk("rst_c_out", {31'h0, c_out}, 32'h1);
      rst = 1'b0;

      // Pure synchronizer latency with injection off.
      repeat (4) @(negedge clk);
      din = 32'h0000_00FF;
      @(negedge clk); chk("lat_1", {24'h0, a_out}, 32'h0000_00A5);
      @(negedge clk); chk("lat_2", {24'h0, a_out}, 32'h0000_00FF);
                      chk("lat_2_rise", {24'h0, a_rise}, 32'h0);
      @(negedge clk); chk("lat_rise", {24'h0, a_rise}, 32'h0000_005A);
                      chk("lat_fall", {24'h0, a_fall}, 32'h0);
      @(negedge clk); chk("lat_rise_end", {24'h0, a_rise}, 32'h0);

      // Injection timing: first mask 8'h03 applied at edge 6.
      rst = 1'b1; meta_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (cyc == 5)  chk("inj_ev5",  {31'h0, a_ev}, 32'h0);
         if (cyc == 6)  chk("inj_ev6",  {31'h0, a_ev}, 32'h1);
         if (cyc == 7)  chk("inj_out7", {24'h0, a_out}, 32'h0000_00FC);
         if (cyc == 8)  chk("inj_out8", {24'h0, a_out}, 32'h0000_00FF);
         if (cyc == 9)  chk("inj_rise9", {24'h0, a_rise}, 32'h0000_0003);
         if (cyc == 11) chk("inj_ev11", {31'h0, a_ev}, 32'h1);
         if (cyc % 3 == 2) din = ~din;
      end

      // Injection off, random data.
      meta_en = 1'b0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(negedge clk);
         din = $urandom;
      end

      // Event counter saturation on the 32-channel, META_COUNT=1 instance.
      rst = 1'b1; meta_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      @(posedge clk); #2;
      force u_b.meta_event_cnt_r = 16'hFFFC;
      force_b = 1'b1;
      m_cnt[1][m_n[1] % HD] = 16'hFFFC;
      @(posedge clk); #2;
      release u_b.meta_event_cnt_r;
      force_b = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         din = $urandom;
      end
      chk("sat_cnt", {16'h0, b_cnt}, 32'h0000_FFFF);

      // Reset in the cycle a nonzero mask is about to be applied.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; din = 32'h0000_00FF;
      for (int i = 0; i < 20 && m_n[0] != 5; i++) @(negedge clk);
      chk("mid_reach", m_n[0], 32'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_out",  {24'h0, a_out},  32'h0000_00A5);
      chk("mid_ev",   {31'h0, a_ev},   32'h0);
      chk("mid_rise", {24'h0, a_rise}, 32'h0);
      rst = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == 6) chk("replay_ev6", {31'h0, a_ev}, 32'h1);
         if (cyc % 3 == 2) din = ~din;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
